// File: rtl/idex_hazard_stage.sv
// Decode-to-execute pipeline register with load-use stall, branch flush and
// saturating stall/flush event counters.
module idex_hazard_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             FlagWD,
  input  logic             NoWriteD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ALUControlD,
  input  logic [1:0]       CondD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             FlagWE,
  output logic             NoWriteE,
  output logic             ALUSrcE,
  output logic [1:0]       ALUControlE,
  output logic [1:0]       CondE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic [3:0]       WA3E,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             flag_w;
    logic             no_write;
    logic             alu_src;
    logic [1:0]       alu_control;
    logic [1:0]       cond;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] ext_imm;
    logic [3:0]       wa3;
    logic             valid;
  } e_slot_t;

  e_slot_t          e_d, e_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             ld_haz, stall, bubble;

  always_comb begin
    ld_haz = e_q.valid & e_q.mem_to_reg & e_q.reg_write &
             ((e_q.wa3 == RA1D) | (e_q.wa3 == RA2D));
    // A taken branch discards the D instruction anyway, so it overrides the stall.
    stall  = ld_haz & ~PCSrcE;
    bubble = ld_haz | PCSrcE;

    e_d = '0;
    if (!bubble) begin
      e_d = '{reg_write: RegWriteD, mem_to_reg: MemtoRegD, mem_write: MemWriteD,
              branch: BranchD, flag_w: FlagWD, no_write: NoWriteD,
              alu_src: ALUSrcD, alu_control: ALUControlD, cond: CondD,
              rd1: RD1D, rd2: RD2D, ext_imm: ExtImmD, wa3: WA3D, valid: 1'b1};
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (PCSrcE && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemtoRegE   = e_q.mem_to_reg;
  assign MemWriteE   = e_q.mem_write;
  assign BranchE     = e_q.branch;
  assign FlagWE      = e_q.flag_w;
  assign NoWriteE    = e_q.no_write;
  assign ALUSrcE     = e_q.alu_src;
  assign ALUControlE = e_q.alu_control;
  assign CondE       = e_q.cond;
  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign ExtImmE     = e_q.ext_imm;
  assign WA3E        = e_q.wa3;
  assign ValidE      = e_q.valid;
  assign StallF      = stall;
  assign StallD      = stall;
  assign FlushD      = PCSrcE;
  assign StallCnt    = stall_cnt_q;
  assign FlushCnt    = flush_cnt_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Bench for idex_hazard_stage: slot-level reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_idex_hazard_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic RegWriteD, MemtoRegD, MemWriteD, BranchD, FlagWD, NoWriteD, ALUSrcD;
  logic [1:0] ALUControlD, CondD;
  logic [WIDTH-1:0] RD1D, RD2D, ExtImmD;
  logic [3:0] RA1D, RA2D, WA3D;
  logic PCSrcE;
  logic RegWriteE, MemtoRegE, MemWriteE, BranchE, FlagWE, NoWriteE, ALUSrcE;
  logic [1:0] ALUControlE, CondE;
  logic [WIDTH-1:0] RD1E, RD2E, ExtImmE;
  logic [3:0] WA3E;
  logic ValidE, StallF, StallD, FlushD;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  idex_hazard_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .FlagWD(FlagWD), .NoWriteD(NoWriteD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .CondD(CondD), .RD1D(RD1D), .RD2D(RD2D),
    .ExtImmD(ExtImmD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .FlagWE(FlagWE), .NoWriteE(NoWriteE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .CondE(CondE), .RD1E(RD1E), .RD2E(RD2E),
    .ExtImmE(ExtImmE), .WA3E(WA3E), .ValidE(ValidE), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // Reference model: the instruction occupying the E slot, and event tallies.
  typedef struct packed {
    logic rw, mtr, mw, br, fw, nw, as;
    logic [1:0] alu, cond;
    logic [WIDTH-1:0] rd1, rd2, imm;
    logic [3:0] wa3;
    logic valid;
  } slot_t;

  slot_t m_slot;
  int    m_stalls, m_flushes;
  bit    m_known = 1'b0;

  function automatic bit model_hazard();
    return m_slot.valid && m_slot.mtr && m_slot.rw &&
           (m_slot.wa3 == RA1D || m_slot.wa3 == RA2D);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_slot = '0;
      m_stalls = 0;
      m_flushes = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (PCSrcE) begin
        if (m_flushes < CNT_MAX) m_flushes++;
        m_slot = '0;
      end else if (model_hazard()) begin
        if (m_stalls < CNT_MAX) m_stalls++;
        m_slot = '0;
      end else begin
        m_slot = '{rw: RegWriteD, mtr: MemtoRegD, mw: MemWriteD, br: BranchD,
                   fw: FlagWD, nw: NoWriteD, as: ALUSrcD, alu: ALUControlD,
                   cond: CondD, rd1: RD1D, rd2: RD2D, imm: ExtImmD, wa3: WA3D,
                   valid: 1'b1};
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  slot_t dut_slot;
  assign dut_slot = '{rw: RegWriteE, mtr: MemtoRegE, mw: MemWriteE, br: BranchE,
                      fw: FlagWE, nw: NoWriteE, as: ALUSrcE, alu: ALUControlE,
                      cond: CondE, rd1: RD1E, rd2: RD2E, imm: ExtImmE, wa3: WA3E,
                      valid: ValidE};

  always @(negedge clk) begin
    if (m_known) begin
      check("e_slot", 128'(dut_slot), 128'(m_slot));
      check("StallF", 128'(StallF), 128'(model_hazard() && !PCSrcE));
      check("StallD", 128'(StallD), 128'(model_hazard() && !PCSrcE));
      check("FlushD", 128'(FlushD), 128'(PCSrcE));
      check("StallCnt", 128'(StallCnt), 128'(m_stalls));
      check("FlushCnt", 128'(FlushCnt), 128'(m_flushes));
    end
  end

  task automatic clear_d();
    {RegWriteD, MemtoRegD, MemWriteD, BranchD, FlagWD, NoWriteD, ALUSrcD} = '0;
    ALUControlD = '0; CondD = '0; RD1D = '0; RD2D = '0; ExtImmD = '0;
    RA1D = '0; RA2D = '0; WA3D = '0; PCSrcE = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_into_e(input logic [3:0] dst);
    clear_d();
    MemtoRegD = 1'b1; RegWriteD = 1'b1; WA3D = dst;
    RA1D = 4'd0; RA2D = 4'd0;
    if (dst == 4'd0) begin RA1D = 4'd1; RA2D = 4'd1; end
    tick();
  endtask

  initial begin
    clear_d();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {RegWriteD, MemtoRegD, MemWriteD, BranchD, FlagWD, NoWriteD, ALUSrcD} = 7'($urandom);
      RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom;
      RA1D = 4'($urandom); RA2D = 4'($urandom); WA3D = 4'($urandom);
      tick();
    end
    @(negedge clk);
    check("rst_valid", 128'(ValidE), 128'(0));
    check("rst_rd1", 128'(RD1E), 128'(0));
    check("rst_cnts", 128'({StallCnt, FlushCnt}), 128'(0));
    check("rst_hazard_outs", 128'({StallF, StallD, FlushD}), 128'(0));

    // Pass-through
    rst = 1'b1;
    clear_d();
    RegWriteD = 1'b1; RD1D = 32'h0000_00AA; WA3D = 4'd3; CondD = 2'b10;
    tick();
    check("pt_regwrite", 128'(RegWriteE), 128'(1));
    check("pt_rd1", 128'(RD1E), 128'h0000_00AA);
    check("pt_wa3", 128'(WA3E), 128'(3));
    check("pt_cond", 128'(CondE), 128'(2'b10));
    check("pt_valid", 128'(ValidE), 128'(1));

    // Load-use on RA1D
    load_into_e(4'd5);
    clear_d();
    RA1D = 4'd5; RegWriteD = 1'b1; WA3D = 4'd6; RD2D = 32'h1234_5678;
    @(negedge clk);
    check("lu_stallf", 128'(StallF), 128'(1));
    check("lu_stalld", 128'(StallD), 128'(1));
    check("lu_flushd", 128'(FlushD), 128'(0));
    tick();
    check("lu_bubble_valid", 128'(ValidE), 128'(0));
    check("lu_stall_release", 128'(StallF), 128'(0));
    check("lu_stallcnt", 128'(StallCnt), 128'(1));
    tick();
    check("lu_replay_wa3", 128'(WA3E), 128'(6));
    check("lu_replay_rd2", 128'(RD2E), 128'h1234_5678);

    // Taken branch
    clear_d();
    BranchD = 1'b1; CondD = 2'b01; ExtImmD = 32'h0000_0040;
    tick();
    check("br_brancheE", 128'(BranchE), 128'(1));
    clear_d();
    RegWriteD = 1'b1; WA3D = 4'd2; PCSrcE = 1'b1;
    @(negedge clk);
    check("br_flushd", 128'(FlushD), 128'(1));
    tick();
    PCSrcE = 1'b0;
    check("br_bubble", 128'({ValidE, BranchE}), 128'(0));
    check("br_flushcnt", 128'(FlushCnt), 128'(1));

    // Load-use and taken branch together, on index 15 via RA2D
    load_into_e(4'd15);
    clear_d();
    RA2D = 4'd15; RegWriteD = 1'b1; WA3D = 4'd4; PCSrcE = 1'b1;
    @(negedge clk);
    check("sim_stalls", 128'({StallF, StallD}), 128'(0));
    check("sim_flushd", 128'(FlushD), 128'(1));
    tick();
    PCSrcE = 1'b0;
    check("sim_bubble", 128'(ValidE), 128'(0));
    check("sim_stallcnt", 128'(StallCnt), 128'(1));
    check("sim_flushcnt", 128'(FlushCnt), 128'(2));

    // Counter saturation at 3 with five load-use stalls
    for (int i = 0; i < 5; i++) begin
      load_into_e(4'd9);
      clear_d();
      RA1D = 4'd9;
      tick();
    end
    check("sat_stallcnt", 128'(StallCnt), 128'(3));

    // Mixed random traffic, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      {RegWriteD, MemtoRegD, MemWriteD, BranchD, FlagWD, NoWriteD, ALUSrcD} = 7'($urandom);
      ALUControlD = 2'($urandom); CondD = 2'($urandom);
      RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom;
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      WA3D = 4'($urandom_range(0, 3));
      PCSrcE = BranchE & ($urandom_range(0, 1) == 1);
      tick();
    end
    check("sat_flushcnt", 128'(FlushCnt), 128'(m_flushes));

    // Reset in the middle of a stall
    load_into_e(4'd7);
    clear_d();
    RA1D = 4'd7;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_stall_seen", 128'(StallF), 128'(1));
    tick();
    check("mid_rst_cnts", 128'({StallCnt, FlushCnt}), 128'(0));
    check("mid_rst_valid", 128'(ValidE), 128'(0));
    rst = 1'b1;
    clear_d();
    tick();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
